// File: rtl/decode_stage.sv
// Decode stage: 4-entry register file with write-bypass and a pending-write scoreboard.
// Issues one instruction per accept, stalling via in_ready while a source is still in flight.
module decode_stage #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       instr,
   input  logic              wb_en,
   input  logic [1:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [1:0]        op,
   output logic [DATA_W-1:0] src1_value,
   output logic [DATA_W-1:0] src2_value,
   output logic [1:0]        out_dst,
   output logic              out_valid
);

   logic [DATA_W-1:0] regs_q [4];
   logic [DATA_W-1:0] regs_d [4];
   logic [3:0]        pending_q, pending_d;
   logic [1:0]        op_q, op_d;
   logic [DATA_W-1:0] src1_q, src1_d;
   logic [DATA_W-1:0] src2_q, src2_d;
   logic [1:0]        dst_q, dst_d;
   logic              valid_q, valid_d;

   logic [1:0]        instr_op, rd, rs1, rs2;
   logic              imm_sel;
   logic [7:0]        imm8;
   logic [DATA_W-1:0] imm_ext;
   logic              byp1, byp2, haz1, haz2, accept;
   logic [DATA_W-1:0] rs1_val, rs2_val;
   logic              unused_reserved;

   assign instr_op        = instr[15:14];
   assign rd              = instr[13:12];
   assign rs1             = instr[11:10];
   assign imm_sel         = instr[9];
   assign unused_reserved = instr[8];
   assign imm8            = instr[7:0];
   assign rs2             = instr[1:0];
   assign imm_ext         = DATA_W'(imm8);

   // A writeback landing this cycle both forwards its data and resolves the hazard it clears.
   assign byp1    = wb_en && (wb_addr == rs1);
   assign byp2    = wb_en && (wb_addr == rs2);
   assign rs1_val = byp1 ? wb_data : regs_q[rs1];
   assign rs2_val = byp2 ? wb_data : regs_q[rs2];

   assign haz1     = pending_q[rs1] && !byp1;
   assign haz2     = !imm_sel && pending_q[rs2] && !byp2;
   assign in_ready = !(haz1 || haz2);
   assign accept   = in_valid && in_ready;

   always_comb begin
      regs_d    = regs_q;
      pending_d = pending_q;
      op_d      = op_q;
      src1_d    = src1_q;
      src2_d    = src2_q;
      dst_d     = dst_q;
      valid_d   = accept;
      if (wb_en) begin
         regs_d[wb_addr]    = wb_data;
         pending_d[wb_addr] = 1'b0;
      end
      // Set after clear so an issue to the register being written back stays pending.
      if (accept) begin
         pending_d[rd] = 1'b1;
         op_d          = instr_op;
         src1_d        = rs1_val;
         src2_d        = imm_sel ? imm_ext : rs2_val;
         dst_d         = rd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
         pending_q <= '0;
         op_q      <= '0;
         src1_q    <= '0;
         src2_q    <= '0;
         dst_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         regs_q    <= regs_d;
         pending_q <= pending_d;
         op_q      <= op_d;
         src1_q    <= src1_d;
         src2_q    <= src2_d;
         dst_q     <= dst_d;
         valid_q   <= valid_d;
      end
   end

   assign op         = op_q;
   assign src1_value = src1_q;
   assign src2_value = src2_q;
   assign out_dst    = dst_q;
   assign out_valid  = valid_q;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the register-file and operand width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  SHALL indicate that instr is presented.
REQ-005 in_ready  output  1  SHALL indicate that the stage accepts instr this cycle; it is combinational, with no hazard.
REQ-006 instr  input  16  SHALL be the instruction word.
- [15:14] op
- [13:12] rd
- [11:10] rs1
- [9] imm_sel
- [8] reserved
- [7:0] imm8 when imm_sel=1
- [1:0] rs2 when imm_sel=0
REQ-007 wb_en  input  1  SHALL be the writeback write strobe from the downstream stage.
REQ-008 wb_addr  input  2  SHALL be the writeback register index.
REQ-009 wb_data  input  DATA_W  SHALL be the writeback data.
REQ-010 op  output  2  SHALL carry the registered ALU opcode to the execute stage.
REQ-011 src1_value  output  DATA_W  SHALL carry the registered operand 1.
REQ-012 src2_value  output  DATA_W  SHALL carry the registered operand 2.
REQ-013 out_dst  output  2  SHALL carry the registered destination index of the issued instruction.
REQ-014 out_valid  output  1  SHALL be a registered one-cycle pulse per issued instruction.

Function
REQ-015 The stage SHALL hold 4 registers r0..r3, each DATA_W wide, and a 4-bit pending scoreboard.
REQ-016 Accept SHALL be defined as in_valid && in_ready.
- On accept, the stage SHALL issue the instruction on the next edge with latency 1.
- out_valid SHALL be 1 for exactly that cycle.
REQ-017 Without an accept, out_valid SHALL be 0, and op, src1_value, src2_value and out_dst SHALL hold their previous values.
REQ-018 Operand source SHALL be selected as follows:
- src1 = read(rs1).
- src2 = read(rs2) if imm_sel=0.
- src2 = imm8 zero-extended/truncated to DATA_W if imm_sel=1.
REQ-019 read(x) SHALL return wb_data if wb_en && wb_addr==x in the same cycle (write-bypass), else r[x].
REQ-020 When wb_en=1, r[wb_addr] SHALL be updated with wb_data at the edge, independent of in_valid or in_ready.
REQ-021 A source is hazardous when pending[src]=1 and no same-cycle bypass (wb_en && wb_addr==src) applies.
- When imm_sel=1, rs2 SHALL NOT be checked.
- When any checked source is hazardous, in_ready SHALL be 0.
REQ-022 Scoreboard updates SHALL occur per edge.
- wb_en clears pending[wb_addr].
- An accept sets pending[rd].
- If both target the same index, set SHALL win.
REQ-023 rd==rs1 or rd==rs2 SHALL be legal; the operand SHALL use the pre-issue value, and pending[rd] SHALL be set afterwards.
REQ-024 When in_valid=0, in_ready SHALL still reflect the hazard check of whatever is on instr, and no state other than the register file and scoreboard clears SHALL change.
REQ-025 Bit [8] and, when imm_sel=0, bits [7:2] SHALL be ignored.
REQ-026 Arithmetic for op encodings (00 add, 01 sub, 10 mul, 11 div) SHALL NOT be performed here; op SHALL pass through unmodified.
REQ-027 A wb_en to a register with pending=0 SHALL write the register and leave the scoreboard unchanged.

Reset
REQ-028 While reset=1 at an edge, r0..r3, pending, op, src1_value, src2_value, out_dst and out_valid SHALL all become 0.
REQ-029 Reset SHALL override any simultaneous accept or wb_en in the same cycle: no write, and no scoreboard set.
REQ-030 During a reset cycle, in_ready SHALL evaluate against the pre-reset scoreboard; the first cycle after reset SHALL see pending=0 and in_ready=1.
REQ-031 Reset asserted mid-stream SHALL discard any in-flight pending state, so instructions after reset never stall on pre-reset hazards.

Verification
REQ-032 Reset, then wb r1=5, r2=3; instr op=00, rd=0, rs1=1, rs2=2 -> next cycle out_valid=1, op=00, src1=5, src2=3, out_dst=0, pending[0]=1.
REQ-033 imm_sel=1, rs1=1 (r1=5), imm8=0x2A, op=10 -> src2=0x2A, src1=5; rs2 field=3 with pending[3]=1 SHALL NOT stall.
REQ-034 Issue rd=2, then next instr reads rs1=2 with no wb -> in_ready=0 and out_valid=0 with outputs held; in the cycle wb_en=1, wb_addr=2, wb_data=9 -> in_ready=1, and the following cycle src1=9.
REQ-035 Same-cycle wb_addr=3 clear and accept with rd=3 -> pending[3]=1 after the edge.
REQ-036 With pending[1]=1 and in_valid=1 stalled, assert reset for 1 cycle -> all outputs 0 and pending=0; the held instruction is accepted the cycle after reset deasserts, with operand values 0.
REQ-037 Back-to-back independent instrs (rd=0, then rd=1, sources r2/r3) -> in_ready stays 1 and out_valid=1 on two consecutive cycles.
